sgd_model_update: RTL and testbench
===================================

Name: sgd_model_update

Overview:
- Downstream stage of the per-bit gradient engine.
- Accumulates the per-chunk gradient vectors it emits over a mini-batch of samples.
- At each batch boundary, applies x <= x - (g >>> step_shift) to an on-chip model store.
- Provides a 1-cycle-latency read port so the upstream dot-product stage can fetch model chunks.

Parameters:
LANES, 8, features per chunk (equals NUM_BITS_PER_BANK of the gradient engine)
DEPTH, 64, maximum chunks per sample held in model and gradient stores
AW, 6, chunk address width (log2 DEPTH)

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is asynchronous and active-high
started  input  1  level enable; low forces IDLE
num_chunks  input  12  chunks per sample, legal range 1..DEPTH, sampled on IDLE->ACCUM
batch_size  input  16  samples per mini-batch, legal range >=1, sampled on IDLE->ACCUM
step_shift  input  5  arithmetic right shift applied to the accumulated gradient
grad_in  input  LANES*32  signed gradient lanes; lane k at bits [32k+31:32k]
grad_in_valid  input  1  one chunk of the current sample, chunks in order 0..num_chunks-1
x_rd_addr  input  AW  model chunk address
x_rd_data  output  LANES*32  registered model chunk read
busy  output  1  high in UPDATE; upstream must not issue grad_in_valid
batch_done  output  1  one-cycle pulse after a batch update completes
overrun_err  output  1  sticky; set when grad_in_valid arrives in IDLE or UPDATE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all counters 0.
  - Model store and gradient store cleared to 0.
  - x_rd_data=0, busy=0, batch_done=0, overrun_err=0.
  - Reset mid-UPDATE abandons the update; the model stays zero.
- States:
  - IDLE -> ACCUM when started=1; chunk_idx=0, sample_idx=0.
  - ACCUM -> UPDATE on the accepted beat with chunk_idx==num_chunks-1 and sample_idx==batch_size-1.
  - UPDATE -> ACCUM after num_chunks cycles; batch_done pulses the cycle state re-enters ACCUM.
  - started=0 forces IDLE next cycle from any state; an in-flight UPDATE is aborted and partially applied chunks remain.
- ACCUM, per grad_in_valid beat (no backpressure, back-to-back beats legal):
  - Each lane is sign-extended to 36 bits.
  - If sample_idx==0, the gradient store chunk is overwritten with the beat; otherwise the beat is added to it (36-bit two's-complement wrap).
  - The read-modify-write completes in 1 cycle; an add to the same chunk on the next beat sees the updated value.
  - chunk_idx increments and wraps to 0 at num_chunks-1; sample_idx increments at that wrap.
- UPDATE: one chunk per cycle, addresses 0..num_chunks-1.
  - delta = g >>> step_shift (arithmetic, floor), saturated to signed 32-bit.
  - x_new = x - delta, saturated to [-2^31, 2^31-1].
  - The model store is written on that cycle's edge.
- busy is registered and equals (state==UPDATE).
- grad_in_valid while state is IDLE or UPDATE: the beat is dropped and overrun_err is set, held until reset.
- Read port:
  - x_rd_data <= model[x_rd_addr] every cycle, 1-cycle latency.
  - A read of the chunk being written in the same cycle returns the old value.
- Addresses >= num_chunks are never written; reads of them return the stored value (0 after reset).
- Illegal config (num_chunks=0 or >DEPTH, batch_size=0): behaviour undefined; the bench shall not drive it.

Test Plan:
- LANES=8, num_chunks=2, batch_size=1, step_shift=0; beats all-lanes +5 then +3 -> busy high exactly 2 cycles, batch_done pulse 1 cycle, then read addr0 -> every lane -5, addr1 -> -3.
- batch_size=3, num_chunks=1, step_shift=2; three beats of +4 -> delta 3, model lane value -3; a second batch of the same three beats -> -6 (store overwritten at sample 0, not carried over).
- Negative floor: single beat -1, step_shift=1 -> delta -1, model +1.
- Saturation: batch_size=2, step_shift=0, beats 0x7FFFFFFF twice (acc 2^32-2) -> delta saturates to 2^31-1, model -(2^31-1); a second identical batch -> model -2^31 (saturated).
- grad_in_valid asserted during UPDATE -> beat dropped, overrun_err=1 and held, model result unchanged versus the clean run.
- Assert rst on the second UPDATE cycle of a 4-chunk update -> all outputs 0 next cycle, all four model chunks read back 0, state IDLE.

Source files
------------

// File: rtl/sgd_model_update.sv
// Mini-batch SGD model store: accumulates per-chunk gradient beats over a batch, then
// applies x <= x - (g >>> step_shift) with saturation, one chunk per cycle.
module sgd_model_update #(
    parameter int LANES = 8,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  started,
    input  logic [11:0]           num_chunks,
    input  logic [15:0]           batch_size,
    input  logic [4:0]            step_shift,
    input  logic [LANES*32-1:0]   grad_in,
    input  logic                  grad_in_valid,
    input  logic [AW-1:0]         x_rd_addr,
    output logic [LANES*32-1:0]   x_rd_data,
    output logic                  busy,
    output logic                  batch_done,
    output logic                  overrun_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_UPDATE
    } state_t;

    typedef logic signed [35:0] acc_t;
    typedef logic signed [31:0] word_t;

    state_t                state_q;
    logic [11:0]           num_chunks_q;
    logic [15:0]           batch_size_q;
    logic [AW-1:0]         chunk_idx_q;
    logic [15:0]           sample_idx_q;
    logic [AW-1:0]         upd_idx_q;
    logic                  busy_q;
    logic                  batch_done_q;
    logic                  overrun_q;
    logic [LANES*32-1:0]   x_rd_q;

    acc_t                  grad_mem_q  [DEPTH][LANES];
    logic [LANES*32-1:0]   model_mem_q [DEPTH];

    logic                  last_chunk;
    logic                  last_sample;
    logic                  last_upd;
    logic                  accept;
    logic                  upd_we;
    acc_t                  grad_wr_d [LANES];
    logic [LANES*32-1:0]   x_new_d;

    function automatic word_t sat_word(input acc_t v);
        if (v > 36'sd2147483647) begin
            return 32'sh7FFF_FFFF;
        end else if (v < -36'sd2147483648) begin
            return 32'sh8000_0000;
        end else begin
            return v[31:0];
        end
    endfunction

    // Both the shifted gradient and the subtraction are clamped to signed 32 bits.
    function automatic word_t update_lane(input acc_t g, input word_t x, input logic [4:0] sh);
        word_t delta;
        acc_t  diff;
        delta = sat_word(g >>> sh);
        diff  = acc_t'(x) - acc_t'(delta);
        return sat_word(diff);
    endfunction

    always_comb begin
        last_chunk  = (12'(chunk_idx_q) == num_chunks_q - 12'd1);
        last_sample = (sample_idx_q == batch_size_q - 16'd1);
        last_upd    = (12'(upd_idx_q) == num_chunks_q - 12'd1);
        accept      = (state_q == S_ACCUM) && started && grad_in_valid;
        upd_we      = (state_q == S_UPDATE) && started;
    end

    // The first sample of a batch overwrites the stored chunk so nothing leaks between batches.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            grad_wr_d[k] = acc_t'($signed(grad_in[32*k +: 32]));
            if (sample_idx_q != 16'd0) begin
                grad_wr_d[k] = grad_wr_d[k] + grad_mem_q[chunk_idx_q][k];
            end
        end
    end

    always_comb begin
        x_new_d = '0;
        for (int k = 0; k < LANES; k++) begin
            x_new_d[32*k +: 32] = update_lane(grad_mem_q[upd_idx_q][k],
                                              model_mem_q[upd_idx_q][32*k +: 32],
                                              step_shift);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of every other register, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            num_chunks_q <= '0;
            batch_size_q <= '0;
            chunk_idx_q  <= '0;
            sample_idx_q <= '0;
            upd_idx_q    <= '0;
            busy_q       <= 1'b0;
            batch_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            batch_done_q <= 1'b0;
            if (grad_in_valid && (state_q != S_ACCUM)) begin
                overrun_q <= 1'b1;
            end
            if (!started) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q      <= S_ACCUM;
                        num_chunks_q <= num_chunks;
                        batch_size_q <= batch_size;
                        chunk_idx_q  <= '0;
                        sample_idx_q <= '0;
                    end
                    S_ACCUM: begin
                        if (grad_in_valid) begin
                            if (last_chunk) begin
                                chunk_idx_q <= '0;
                                if (last_sample) begin
                                    sample_idx_q <= '0;
                                    upd_idx_q    <= '0;
                                    state_q      <= S_UPDATE;
                                    busy_q       <= 1'b1;
                                end else begin
                                    sample_idx_q <= sample_idx_q + 16'd1;
                                end
                            end else begin
                                chunk_idx_q <= chunk_idx_q + AW'(1);
                            end
                        end
                    end
                    S_UPDATE: begin
                        if (last_upd) begin
                            state_q      <= S_ACCUM;
                            busy_q       <= 1'b0;
                            batch_done_q <= 1'b1;
                        end else begin
                            upd_idx_q <= upd_idx_q + AW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // NOTE: both stores must read back as zero after reset, so they are flop arrays
    // cleared by the reset branch rather than RAM macros without a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                model_mem_q[i] <= '0;
                for (int k = 0; k < LANES; k++) begin
                    grad_mem_q[i][k] <= '0;
                end
            end
            x_rd_q <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < LANES; k++) begin
                    grad_mem_q[chunk_idx_q][k] <= grad_wr_d[k];
                end
            end
            if (upd_we) begin
                model_mem_q[upd_idx_q] <= x_new_d;
            end
            x_rd_q <= model_mem_q[x_rd_addr];
        end
    end

    assign x_rd_data   = x_rd_q;
    assign busy        = busy_q;
    assign batch_done  = batch_done_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_sgd_model_update.sv
// Self-checking bench for sgd_model_update: directed batches plus randomized batches
// compared against a sum-then-shift reference of the model store.
module tb_sgd_model_update;

    localparam int LANES = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int W     = LANES * 32;

    logic           clk           = 1'b0;
    logic           rst           = 1'b1;
    logic           started       = 1'b0;
    logic [11:0]    num_chunks    = 12'd1;
    logic [15:0]    batch_size    = 16'd1;
    logic [4:0]     step_shift    = 5'd0;
    logic [W-1:0]   grad_in       = '0;
    logic           grad_in_valid = 1'b0;
    logic [AW-1:0]  x_rd_addr     = '0;
    logic [W-1:0]   x_rd_data;
    logic           busy;
    logic           batch_done;
    logic           overrun_err;

    int             checks = 0;
    int             errors = 0;
    longint         ref_x [DEPTH][LANES];
    logic [W-1:0]   beats [64];

    always #5 clk = ~clk;

    sgd_model_update #(.LANES(LANES), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .started       (started),
        .num_chunks    (num_chunks),
        .batch_size    (batch_size),
        .step_shift    (step_shift),
        .grad_in       (grad_in),
        .grad_in_valid (grad_in_valid),
        .x_rd_addr     (x_rd_addr),
        .x_rd_data     (x_rd_data),
        .busy          (busy),
        .batch_done    (batch_done),
        .overrun_err   (overrun_err)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] splat(input logic [31:0] v);
        return {LANES{v}};
    endfunction

    function automatic longint clamp32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic longint wrap36(input longint v);
        longint m;
        m = v & ((64'sd1 <<< 36) - 1);
        if (m >= (64'sd1 <<< 35)) m = m - (64'sd1 <<< 36);
        return m;
    endfunction

    function automatic logic [W-1:0] pack_chunk(input int a);
        logic [W-1:0] r;
        for (int k = 0; k < LANES; k++) r[32*k +: 32] = 32'(ref_x[a][k]);
        return r;
    endfunction

    // Reference: sum the batch per lane, floor-shift, clamp, subtract, clamp.
    task automatic ref_apply(input int nc, input int bs, input int sh);
        for (int c = 0; c < nc; c++) begin
            for (int k = 0; k < LANES; k++) begin
                longint g;
                longint delta;
                int     v;
                g = 0;
                for (int s = 0; s < bs; s++) begin
                    v = beats[s*nc + c][32*k +: 32];
                    g = g + longint'(v);
                end
                g = wrap36(g);
                delta = clamp32(g >>> sh);
                ref_x[c][k] = clamp32(ref_x[c][k] - delta);
            end
        end
    endtask

    task automatic ref_clear();
        for (int a = 0; a < DEPTH; a++)
            for (int k = 0; k < LANES; k++) ref_x[a][k] = 0;
    endtask

    task automatic do_reset();
        started = 1'b0;
        grad_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_clear();
    endtask

    task automatic configure(input int nc, input int bs, input int sh);
        started = 1'b0;
        @(posedge clk); #1;
        num_chunks = 12'(nc);
        batch_size = 16'(bs);
        step_shift = 5'(sh);
        started    = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drive_beats(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            grad_in = beats[i];
            grad_in_valid = 1'b1;
            @(posedge clk); #1;
            grad_in_valid = 1'b0;
            if (gaps && i != n - 1) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic wait_update(input string tag, input int nc, input bit inject, input bit exp_ovr);
        int busy_cycles;
        int budget;
        bit done;
        busy_cycles = 0;
        budget = 0;
        done = 1'b0;
        while (!done && budget < 300) begin
            if (busy) begin
                busy_cycles++;
                if (inject && busy_cycles == 1) begin
                    grad_in = splat(32'h1234_5678);
                    grad_in_valid = 1'b1;
                end
            end
            if (batch_done) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                grad_in_valid = 1'b0;
                budget++;
            end
        end
        check($sformatf("%s_done_seen", tag), W'(done), W'(1));
        check($sformatf("%s_busy_cycles", tag), W'(busy_cycles), W'(nc));
        check($sformatf("%s_busy_low_at_done", tag), W'(busy), W'(0));
        @(posedge clk); #1;
        check($sformatf("%s_done_pulse", tag), W'(batch_done), W'(0));
        check($sformatf("%s_overrun", tag), W'(overrun_err), W'(exp_ovr));
    endtask

    task automatic check_model(input string tag, input int naddr);
        for (int a = 0; a < naddr; a++) begin
            x_rd_addr = AW'(a);
            @(posedge clk); #1;
            check($sformatf("%s_x%0d", tag, a), x_rd_data, pack_chunk(a));
        end
    endtask

    task automatic batch(input string tag, input int nc, input int bs, input int sh,
                         input bit gaps, input bit inject, input bit exp_ovr);
        drive_beats(nc * bs, gaps);
        wait_update(tag, nc, inject, exp_ovr);
        ref_apply(nc, bs, sh);
    endtask

    initial begin
        ref_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_x_rd_data", x_rd_data, '0);
        check("rst_busy", W'(busy), W'(0));
        check("rst_batch_done", W'(batch_done), W'(0));
        check("rst_overrun", W'(overrun_err), W'(0));
        rst = 1'b0;

        // Two chunks, one sample, no shift.
        configure(2, 1, 0);
        beats[0] = splat(32'd5);
        beats[1] = splat(32'd3);
        batch("t1", 2, 1, 0, 1'b0, 1'b0, 1'b0);
        check_model("t1", 3);
        x_rd_addr = AW'(0);
        @(posedge clk); #1;
        check("t1_x0_const", x_rd_data, splat(32'hFFFF_FFFB));
        x_rd_addr = AW'(1);
        @(posedge clk); #1;
        check("t1_x1_const", x_rd_data, splat(32'hFFFF_FFFD));

        // Three back-to-back beats into one chunk, then a second identical batch.
        do_reset();
        configure(1, 3, 2);
        for (int i = 0; i < 3; i++) beats[i] = splat(32'd4);
        batch("t2a", 1, 3, 2, 1'b0, 1'b0, 1'b0);
        check_model("t2a", 1);
        batch("t2b", 1, 3, 2, 1'b0, 1'b0, 1'b0);
        check_model("t2b", 1);
        x_rd_addr = AW'(0);
        @(posedge clk); #1;
        check("t2b_x0_const", x_rd_data, splat(32'hFFFF_FFFA));

        // Floor of a negative shift.
        do_reset();
        configure(1, 1, 1);
        beats[0] = splat(32'hFFFF_FFFF);
        batch("t3", 1, 1, 1, 1'b0, 1'b0, 1'b0);
        check_model("t3", 1);

        // Saturation of delta, then of the model itself.
        do_reset();
        configure(1, 2, 0);
        beats[0] = splat(32'h7FFF_FFFF);
        beats[1] = splat(32'h7FFF_FFFF);
        batch("t4a", 1, 2, 0, 1'b0, 1'b0, 1'b0);
        check_model("t4a", 1);
        batch("t4b", 1, 2, 0, 1'b0, 1'b0, 1'b0);
        check_model("t4b", 1);
        x_rd_addr = AW'(0);
        @(posedge clk); #1;
        check("t4b_x0_const", x_rd_data, splat(32'h8000_0000));

        // A beat during UPDATE is dropped and flags overrun.
        do_reset();
        configure(2, 1, 0);
        beats[0] = splat(32'd5);
        beats[1] = splat(32'd3);
        batch("t5", 2, 1, 0, 1'b0, 1'b1, 1'b1);
        check_model("t5", 2);
        check("t5_overrun_held", W'(overrun_err), W'(1));

        // Reset on the second cycle of a four-chunk update.
        do_reset();
        configure(4, 1, 0);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < LANES; k++) beats[i][32*k +: 32] = $urandom();
        drive_beats(4, 1'b0);
        check("t6_busy_upd0", W'(busy), W'(1));
        @(posedge clk); #1;
        check("t6_busy_upd1", W'(busy), W'(1));
        rst = 1'b1;
        started = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_busy", W'(busy), W'(0));
        check("t6_rst_done", W'(batch_done), W'(0));
        check("t6_rst_overrun", W'(overrun_err), W'(0));
        check("t6_rst_x_rd", x_rd_data, '0);
        rst = 1'b0;
        ref_clear();
        check_model("t6", 4);
        grad_in_valid = 1'b1;
        @(posedge clk); #1;
        grad_in_valid = 1'b0;
        check("t6_idle_overrun", W'(overrun_err), W'(1));

        // Randomized configurations and beats, with idle gaps between beats.
        do_reset();
        for (int r = 0; r < 6; r++) begin
            int nc;
            int bs;
            int sh;
            int nb;
            nc = $urandom_range(1, 4);
            bs = $urandom_range(1, 3);
            sh = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 31);
            nb = $urandom_range(1, 2);
            configure(nc, bs, sh);
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < nc * bs; i++)
                    for (int k = 0; k < LANES; k++) beats[i][32*k +: 32] = $urandom();
                batch($sformatf("rnd%0d_%0d", r, b), nc, bs, sh, 1'b1, 1'b0, 1'b0);
                check_model($sformatf("rnd%0d_%0d", r, b), 6);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
